// File: rtl/input_route_unit.sv
// ============================================================================
// Module  : input_route_unit (with NoC field package params_noc)
// Brief   : Router input stage: pops a FWFT buffer, registers one flit, tracks
//           packet framing and latches a dimension-ordered route on each head.
//           Define ROUTE_YX_EN for YX dimension order (default is XY).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package params_noc;
    localparam int FLIT_W    = 32;
    localparam int X_W       = 4;
    localparam int Y_W       = 4;
    localparam int PAYLOAD_W = FLIT_W - 2 - X_W - Y_W;

    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'd0,
        FLIT_BODY     = 2'd1,
        FLIT_TAIL     = 2'd2,
        FLIT_HEADTAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t             flit_type;
        logic [X_W-1:0]         x_Dest;
        logic [Y_W-1:0]         y_Dest;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_Data_noVC;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_SOUTH = 3'd2;
    localparam logic [2:0] PORT_EAST  = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;
endpackage

module input_route_unit
    import params_noc::*;
#(
    parameter logic [X_W-1:0] X_CURRENT = '0,
    parameter logic [Y_W-1:0] Y_CURRENT = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           buf_empty,
    input  flit_Data_noVC  flit_i,
    output logic           read_o,
    output flit_Data_noVC  flit_o,
    output logic           valid_o,
    output logic [2:0]     out_port_o,
    input  logic           grant_i,
    output logic           err_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t         state_q, state_d;
    flit_Data_noVC  flit_q, flit_d;
    logic           valid_q, valid_d;
    logic [2:0]     port_q, port_d;
    logic           err_q, err_d;
    logic           load;
    logic           is_head;

    // Mesh routing: plain unsigned compares, no wrap-around.
    function automatic logic [2:0] route_f(input logic [X_W-1:0] xd,
                                           input logic [Y_W-1:0] yd);
        logic [2:0] p;
`ifdef ROUTE_YX_EN
        if (yd > Y_CURRENT)       p = PORT_SOUTH;
        else if (yd < Y_CURRENT)  p = PORT_NORTH;
        else if (xd > X_CURRENT)  p = PORT_EAST;
        else if (xd < X_CURRENT)  p = PORT_WEST;
        else                      p = PORT_LOCAL;
`else
        if (xd > X_CURRENT)       p = PORT_EAST;
        else if (xd < X_CURRENT)  p = PORT_WEST;
        else if (yd > Y_CURRENT)  p = PORT_SOUTH;
        else if (yd < Y_CURRENT)  p = PORT_NORTH;
        else                      p = PORT_LOCAL;
`endif
        return p;
    endfunction

    // The output slot is free when empty or being drained by the switch.
    assign load    = !buf_empty && (!valid_q || grant_i);
    assign read_o  = load && rst_n;
    assign is_head = (flit_i.flit_type == FLIT_HEAD) ||
                     (flit_i.flit_type == FLIT_HEADTAIL);

    always_comb begin
        state_d = state_q;
        flit_d  = flit_q;
        valid_d = valid_q;
        port_d  = port_q;
        err_d   = 1'b0;

        if (load) begin
            if (is_head) begin
                // A head while a packet is open abandons the old packet.
                err_d   = (state_q == ST_ACTIVE);
                port_d  = route_f(flit_i.x_Dest, flit_i.y_Dest);
                flit_d  = flit_i;
                valid_d = 1'b1;
                state_d = (flit_i.flit_type == FLIT_HEAD) ? ST_ACTIVE : ST_IDLE;
            end else if (state_q == ST_IDLE) begin
                // Orphan body/tail: drop it so the buffer cannot stall.
                err_d   = 1'b1;
                valid_d = 1'b0;
            end else begin
                flit_d  = flit_i;
                valid_d = 1'b1;
                state_d = (flit_i.flit_type == FLIT_TAIL) ? ST_IDLE : ST_ACTIVE;
            end
        end else if (grant_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            flit_q  <= '0;
            valid_q <= 1'b0;
            port_q  <= PORT_LOCAL;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            valid_q <= valid_d;
            port_q  <= port_d;
            err_q   <= err_d;
        end
    end

    assign flit_o     = flit_q;
    assign valid_o    = valid_q;
    assign out_port_o = port_q;
    assign err_o      = err_q;

endmodule

`default_nettype wire
